// File: rtl/mul_sig_misr.sv
// Purpose: MISR signature compressor (taps 63,2,0) for multiplier results, with an end-of-run compare against EXPECT.
// Latency: sig/count update on the accepting edge; done/pass follow one cycle after the final beat. Backpressure: in_ready only in RUN.
// Optional operand self-check (op_a/op_b/err) is enabled with `define MUL_SIG_SELFCHK_EN.
module mul_sig_misr #(
  parameter int unsigned NSAMP  = 88,
  parameter logic [63:0] SEED   = 64'h0,
  parameter logic [63:0] EXPECT = 64'h0
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [63:0] sig,
  output logic [15:0] count
`ifdef MUL_SIG_SELFCHK_EN
  ,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [63:0] r_sig;
  logic [15:0] r_count;

  logic        w_accept;
  logic        w_start_ok;
  logic        w_last;
  logic [63:0] w_next_sig;

  assign w_accept   = r_in_ready & in_valid;
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last     = (r_count == 16'(NSAMP - 1));
  assign w_next_sig = {r_sig[62:0], r_sig[63] ^ r_sig[2] ^ r_sig[0]} ^ in_data;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_sig      <= 64'h0;
      r_count    <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_sig      <= SEED;
            r_count    <= 16'h0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_sig   <= w_next_sig;
            r_count <= r_count + 16'd1;
            // Drop ready on the final beat so nothing beyond NSAMP is consumed.
            if (w_last) begin
              r_in_ready <= 1'b0;
              r_state    <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          r_pass  <= (r_sig == EXPECT);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign sig      = r_sig;
  assign count    = r_count;

`ifdef MUL_SIG_SELFCHK_EN
  logic        r_err;
  logic [31:0] w_sa;
  logic [31:0] w_sb;
  logic [31:0] w_sprod;
  logic [31:0] w_uprod;
  logic        w_mismatch;

  // Low 32 bits of a two's-complement product equal the signed product.
  assign w_sa       = {{16{op_a[15]}}, op_a};
  assign w_sb       = {{16{op_b[15]}}, op_b};
  assign w_sprod    = w_sa * w_sb;
  assign w_uprod    = {16'h0, op_a} * {16'h0, op_b};
  assign w_mismatch = (w_sprod != in_data[31:0]) | (w_uprod != in_data[63:32]);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_accept && w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule
